adder_sweep_checker: RTL and testbench

Sequential self-checking driver for the combinational `adder_2bit` datapath. On a start request it walks every operand pair {A,B} through the adder, waits a programmable settle time, and compares {Carry,Sum} against the arithmetic sum. It reports pass/fail, an error count and the first failing vector. It sits directly upstream of the adder (drives A/B) and consumes its outputs, replacing the hand-written vector list used in simulation with a synthesizable on-board checker.

---
 rtl/adder_sweep_checker.sv | 139 +++++++++++++
 tb/tb_adder_sweep_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_sweep_checker
// Purpose  : Drives every {A,B} operand pair into an external adder, waits
//            SETTLE cycles, then compares {Carry,Sum} against A+B. Reports
//            pass/fail, error count and the first failing vector.
//            Optional macro: SWEEP_ABORT_ON_FAIL_EN (stop at first mismatch).
// Revision : 1.0  initial release
// ============================================================================
module adder_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   Sum,
    input  logic               Carry,
    output logic               Busy,
    output logic               Done,
    output logic               Pass,
    output logic [2*WIDTH:0]   ErrCount,
    output logic [2*WIDTH-1:0] FailVec,
    output logic               FailValid
);

    localparam int VW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(SETTLE - 1);

`ifdef SWEEP_ABORT_ON_FAIL_EN
    localparam bit C_ABORT_ON_FAIL = 1'b1;
`else
    localparam bit C_ABORT_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   vec_q;
    logic [CW-1:0]   cnt_q;
    logic [EW-1:0]   err_q;
    logic [VW-1:0]   failvec_q;
    logic            failvalid_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic [WIDTH:0]  sum_exp;
    logic            mismatch;
    logic [EW-1:0]   err_d;
    logic            finish_d;

    always_comb begin
        sum_exp  = {1'b0, vec_q[VW-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]};
        mismatch = ({Carry, Sum} != sum_exp);
        err_d    = err_q + {{(EW-1){1'b0}}, mismatch};
        finish_d = (&vec_q) || (C_ABORT_ON_FAIL && mismatch);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            failvec_q   <= '0;
            failvalid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q     <= S_SETTLE;
                        vec_q       <= '0;
                        cnt_q       <= '0;
                        err_q       <= '0;
                        failvec_q   <= '0;
                        failvalid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_q <= S_CHECK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    err_q <= err_d;
                    if (mismatch && !failvalid_q) begin
                        failvec_q   <= vec_q;
                        failvalid_q <= 1'b1;
                    end
                    // Pass is derived from the post-update count so it is valid with Done.
                    if (finish_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        state_q <= S_SETTLE;
                        vec_q   <= vec_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A         = vec_q[VW-1:WIDTH];
    assign B         = vec_q[WIDTH-1:0];
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign ErrCount  = err_q;
    assign FailVec   = failvec_q;
    assign FailValid = failvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_sweep_checker
// Purpose  : Directed bench for adder_sweep_checker with a fault-injectable
//            behavioural adder; honours SWEEP_ABORT_ON_FAIL_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_sweep_checker;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [1:0] A, B, Sum;
    logic       Carry, Busy, Done, Pass, FailValid;
    logic [4:0] ErrCount;
    logic [3:0] FailVec;

    logic       Start1 = 1'b0;
    logic [1:0] A1, B1, Sum1;
    logic       Carry1, Busy1, Done1, Pass1, FailValid1;
    logic [4:0] ErrCount1;
    logic [3:0] FailVec1;

    int fault = 0;
    int n_total = 0;
    int n_bad = 0;
    int cycles, steps;
    bit mono;

    always #5 Clk = ~Clk;

    // Behavioural adder: 0 = correct, 1 = carry stuck at 0, 2 = Sum[0] inverted
    always_comb begin
        logic [2:0] t;
        t = {1'b0, A} + {1'b0, B};
        if (fault == 1) t[2] = 1'b0;
        if (fault == 2) t[0] = ~t[0];
        {Carry, Sum} = t;
    end

    assign {Carry1, Sum1} = {1'b0, A1} + {1'b0, B1};

    adder_sweep_checker #(.WIDTH(2), .SETTLE(2)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B), .Sum(Sum),
        .Carry(Carry), .Busy(Busy), .Done(Done), .Pass(Pass),
        .ErrCount(ErrCount), .FailVec(FailVec), .FailValid(FailValid)
    );

    adder_sweep_checker #(.WIDTH(2), .SETTLE(1)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start1), .A(A1), .B(B1), .Sum(Sum1),
        .Carry(Carry1), .Busy(Busy1), .Done(Done1), .Pass(Pass1),
        .ErrCount(ErrCount1), .FailVec(FailVec1), .FailValid(FailValid1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse Start, then count edges from the accepting edge until Done is seen.
    task automatic sweep(input bit toggle, output int cyc, output int stp, output bit mo);
        logic [3:0] prev;
        cyc = 0; stp = 0; mo = 1'b1;
        @(negedge Clk) Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk) Start = 1'b0;
        check("busy_after_start", {31'd0, Busy}, 32'd1);
        check("vec_after_start", {28'd0, A, B}, 32'd0);
        prev = {A, B};
        while (!Done && cyc < 200) begin
            Start = toggle ? cyc[1] : 1'b0;
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if ({A, B} != prev) begin
                if ({A, B} != prev + 4'd1) mo = 1'b0;
                stp++;
                prev = {A, B};
            end
        end
        Start = 1'b0;
        if (!Done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int exp_cyc1, exp_cyc2, exp_err1, exp_err2;
`ifdef SWEEP_ABORT_ON_FAIL_EN
        exp_cyc1 = 24; exp_cyc2 = 3; exp_err1 = 1; exp_err2 = 1;
`else
        exp_cyc1 = 48; exp_cyc2 = 48; exp_err1 = 6; exp_err2 = 16;
`endif
        repeat (2) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_pass", {31'd0, Pass}, 32'd0);
        check("rst_err", {27'd0, ErrCount}, 32'd0);
        check("rst_failvec", {28'd0, FailVec}, 32'd0);
        check("rst_ab", {28'd0, A, B}, 32'd0);
        Rst_n = 1'b1;

        // Correct adder
        sweep(1'b0, cycles, steps, mono);
        check("ok_cycles", cycles, 48);
        check("ok_pass", {31'd0, Pass}, 32'd1);
        check("ok_err", {27'd0, ErrCount}, 32'd0);
        check("ok_failvalid", {31'd0, FailValid}, 32'd0);
        check("ok_steps", steps, 15);
        check("ok_mono", {31'd0, mono}, 32'd1);
        check("ok_last_vec", {28'd0, A, B}, 32'hF);
        check("ok_busy_done", {31'd0, Busy}, 32'd0);

        // Restart from DONE with Start toggling during the sweep
        sweep(1'b1, cycles, steps, mono);
        check("tog_cycles", cycles, 48);
        check("tog_pass", {31'd0, Pass}, 32'd1);
        check("tog_err", {27'd0, ErrCount}, 32'd0);

        // Carry stuck at 0
        fault = 1;
        sweep(1'b0, cycles, steps, mono);
        check("c0_cycles", cycles, exp_cyc1);
        check("c0_err", {27'd0, ErrCount}, exp_err1);
        check("c0_failvec", {28'd0, FailVec}, 32'h7);
        check("c0_failvalid", {31'd0, FailValid}, 32'd1);
        check("c0_pass", {31'd0, Pass}, 32'd0);

        // Sum[0] inverted
        fault = 2;
        sweep(1'b0, cycles, steps, mono);
        check("s0_cycles", cycles, exp_cyc2);
        check("s0_err", {27'd0, ErrCount}, exp_err2);
        check("s0_failvec", {28'd0, FailVec}, 32'h0);
        check("s0_failvalid", {31'd0, FailValid}, 32'd1);
        check("s0_pass", {31'd0, Pass}, 32'd0);

        // Asynchronous reset mid-sweep
        fault = 0;
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        repeat (20) @(negedge Clk);
        check("mid_busy_before", {31'd0, Busy}, 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, Busy}, 32'd0);
        check("mid_ab", {28'd0, A, B}, 32'd0);
        check("mid_outs", {21'd0, ErrCount, FailVec, FailValid, Pass, Done}, 32'd0);
        @(negedge Clk) Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
        check("post_rst_idle", {29'd0, Busy, Done, Pass}, 32'd0);
        check("post_rst_ab", {28'd0, A, B}, 32'd0);
        sweep(1'b0, cycles, steps, mono);
        check("post_rst_cycles", cycles, 48);
        check("post_rst_pass", {31'd0, Pass}, 32'd1);

        // Start held high: Done lasts exactly one cycle, then a new sweep starts
        Start = 1'b1;
        @(posedge Clk);
        begin
            int k;
            k = 0;
            @(negedge Clk);
            while (!Done && k < 200) begin
                @(posedge Clk);
                k++;
                @(negedge Clk);
            end
            check("hold_cycles", k, 48);
        end
        @(negedge Clk);
        check("hold_done_drop", {31'd0, Done}, 32'd0);
        check("hold_busy", {31'd0, Busy}, 32'd1);
        Start = 1'b0;

        // SETTLE=1 instance
        @(negedge Clk) Start1 = 1'b1;
        @(posedge Clk);
        @(negedge Clk) Start1 = 1'b0;
        begin
            int k;
            k = 0;
            while (!Done1 && k < 200) begin
                @(posedge Clk);
                k++;
                @(negedge Clk);
            end
            check("s1_cycles", k, 32);
        end
        check("s1_pass", {31'd0, Pass1}, 32'd1);
        check("s1_err", {27'd0, ErrCount1}, 32'd0);
        check("s1_failvalid", {31'd0, FailValid1}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
